// File: rtl/xorshift_pkg.sv
// Shared types and constants for the xorshift stream generator family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xorshift_pkg;

    // Generator control states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default shift triple for 32-bit words
    localparam int SH32_A = 13;
    localparam int SH32_B = 17;
    localparam int SH32_C = 5;

    // Default shift triple for 64-bit words
    localparam int SH64_A = 13;
    localparam int SH64_B = 7;
    localparam int SH64_C = 17;

    // An all-zero xorshift state is a fixed point, so a zero seed is replaced by this
    localparam logic [31:0] ZERO_SEED_DEFAULT = 32'h2545F491;

endpackage

// File: rtl/xorshift_stream_gen_step.sv
// Single combinational xorshift step: t=x^(x<<A); t^=t>>B; y=t^(t<<C).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register the result.
// Ports: word (current state), next_word (xs(word)); all shifts logical, truncated to DATA_W.
module xorshift_step
    import xorshift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_A   = SH32_A,
    parameter int SH_B   = SH32_B,
    parameter int SH_C   = SH32_C
) (
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] next_word
);

    logic [DATA_W-1:0] t1;
    logic [DATA_W-1:0] t2;

    assign t1        = word ^ (word << SH_A);
    assign t2        = t1 ^ (t1 >> SH_B);
    assign next_word = t2 ^ (t2 << SH_C);

endmodule

// File: rtl/xorshift_stream_gen.sv
// Seeded xorshift word stream: loads seed/count, emits count words, pulses done.
// Latency: first word valid 1 cycle after accepted in_valid; one bubble between runs.
// Backpressure: out_ready low holds rand_num/out_valid/remaining; abort ends run next cycle.
// Ports: clk, rst_n (sync, active-low); in_valid/seed_in/num_in load a run (ignored while busy);
//        abort; out_ready/out_valid/rand_num stream; busy (run active); done (1-cycle end pulse).
module xorshift_stream_gen
    import xorshift_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          CNT_W     = 8,
    parameter int          SH_A      = SH32_A,
    parameter int          SH_B      = SH32_B,
    parameter int          SH_C      = SH32_C,
    parameter logic [31:0] ZERO_SEED = ZERO_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] seed_in,
    input  logic [CNT_W-1:0]  num_in,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] rand_num,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] ZSEED    = DATA_W'(ZERO_SEED);
    // num_in==0 encodes a full 2**CNT_W run, hence the extra counter bit
    localparam logic [CNT_W:0]    FULL_CNT = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0]    ONE_CNT  = {{CNT_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W:0]    remaining;
    logic [CNT_W:0]    rem_nxt;
    logic [DATA_W-1:0] rand_nxt;
    logic              vld_nxt;
    logic              done_nxt;
    logic [DATA_W-1:0] seed_eff;
    logic [DATA_W-1:0] step_in;
    logic [DATA_W-1:0] step_out;

    assign seed_eff = (seed_in == '0) ? ZSEED : seed_in;

    // One step instance shared: in IDLE it scrambles the seed, in RUN it advances the stream
    assign step_in = (state == IDLE) ? seed_eff : rand_num;

    xorshift_step #(
        .DATA_W (DATA_W),
        .SH_A   (SH_A),
        .SH_B   (SH_B),
        .SH_C   (SH_C)
    ) u_step (
        .word      (step_in),
        .next_word (step_out)
    );

    always_comb begin
        state_nxt = state;
        rand_nxt  = rand_num;
        vld_nxt   = out_valid;
        rem_nxt   = remaining;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                    vld_nxt   = 1'b1;
                    rand_nxt  = step_out;
                    rem_nxt   = (num_in == '0) ? FULL_CNT : {1'b0, num_in};
                end
            end
            RUN: begin
                // abort takes priority; a word on the bus in that cycle is not delivered
                if (abort) begin
                    state_nxt = IDLE;
                    vld_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                end else if (out_valid && out_ready) begin
                    if (remaining == ONE_CNT) begin
                        // last word accepted: rand_num keeps its final value
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        rand_nxt = step_out;
                        rem_nxt  = remaining - ONE_CNT;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rand_num  <= '0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= vld_nxt;
            rand_num  <= rand_nxt;
            done      <= done_nxt;
            remaining <= rem_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_xorshift_stream_gen.sv
// Self-checking bench for xorshift_stream_gen (32-bit and 64-bit instances).
// Latency: n/a.
// Backpressure: drives out_ready patterns (always, random, stalled).
module tb_xorshift_stream_gen;
    import xorshift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv32 = 1'b0, ab32 = 1'b0, rdy32 = 1'b0;
    logic [31:0] seed32 = '0;
    logic [7:0]  num32 = '0;
    logic        v32, busy32, done32;
    logic [31:0] rn32;

    logic        iv64 = 1'b0, ab64 = 1'b0, rdy64 = 1'b0;
    logic [63:0] seed64 = '0;
    logic [7:0]  num64 = '0;
    logic        v64, busy64, done64;
    logic [63:0] rn64;

    int errors = 0;
    int checks = 0;

    logic [31:0] q32[$];
    logic [63:0] q64[$];
    int          xfer32 = 0, xfer64 = 0;
    logic [31:0] first32 = '0, second32 = '0;

    typedef struct {
        logic [31:0] seed;
        logic [7:0]  num;
        int          mode;       // 0: ready always, 1: random ready, 2: ready low 5 cycles
        logic [31:0] exp_first;
        logic [31:0] exp_second;
        int          exp_n;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    xorshift_stream_gen #(
        .DATA_W(32), .CNT_W(8), .SH_A(SH32_A), .SH_B(SH32_B), .SH_C(SH32_C),
        .ZERO_SEED(ZERO_SEED_DEFAULT)
    ) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .seed_in(seed32), .num_in(num32),
        .abort(ab32), .out_ready(rdy32), .out_valid(v32), .rand_num(rn32),
        .busy(busy32), .done(done32)
    );

    xorshift_stream_gen #(
        .DATA_W(64), .CNT_W(8), .SH_A(SH64_A), .SH_B(SH64_B), .SH_C(SH64_C),
        .ZERO_SEED(ZERO_SEED_DEFAULT)
    ) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .seed_in(seed64), .num_in(num64),
        .abort(ab64), .out_ready(rdy64), .out_valid(v64), .rand_num(rn64),
        .busy(busy64), .done(done64)
    );

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        return t ^ (t << 17);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word is compared against the queued model value
    always @(negedge clk) begin
        if (rst_n && v32 && rdy32 && !ab32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word32: got %h expected no word", rn32);
            end else begin
                chk("word32", rn32, q32.pop_front());
            end
            if (xfer32 == 0) first32 = rn32;
            if (xfer32 == 1) second32 = rn32;
            xfer32++;
        end
        if (rst_n && v64 && rdy64 && !ab64) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word64: got %h expected no word", rn64);
            end else begin
                chk("word64", rn64, q64.pop_front());
            end
            xfer64++;
        end
    end

    task automatic run32(input vec_t v);
        logic [31:0] w;
        int c;
        int done_c;
        w = (v.seed == 32'd0) ? 32'h2545F491 : v.seed;
        for (int i = 0; i < v.exp_n; i++) begin
            w = xs32(w);
            q32.push_back(w);
        end
        xfer32 = 0;
        done_c = 0;
        @(posedge clk); #1;
        iv32 = 1'b1; seed32 = v.seed; num32 = v.num; rdy32 = (v.mode != 2);
        @(posedge clk); #1;
        iv32 = 1'b0; seed32 = '0; num32 = '0;
        @(negedge clk);
        chk("load_valid", v32, 1);
        chk("load_busy", busy32, 1);
        chk("first_word_at_load", rn32, v.exp_first);
        c = 1;
        while (done_c == 0 && c < 1000) begin
            @(posedge clk); #1;
            c++;
            case (v.mode)
                1:       rdy32 = 1'($urandom_range(0, 1));
                2:       rdy32 = (c > 5);
                default: rdy32 = 1'b1;
            endcase
            @(negedge clk);
            if (v.mode == 2 && c <= 5) begin
                chk("bp_hold_word", rn32, v.exp_first);
                chk("bp_hold_valid", v32, 1);
            end
            if (done32) done_c = c;
        end
        chk("done_seen", (done_c != 0), 1);
        if (v.mode == 0) chk("done_cycle", done_c, v.exp_n + 1);
        chk("done_busy_low", busy32, 0);
        chk("done_valid_low", v32, 0);
        chk("xfer_count", xfer32, v.exp_n);
        chk("queue_drained", q32.size(), 0);
        chk("first_word", first32, v.exp_first);
        if (v.exp_n >= 2) chk("second_word", second32, v.exp_second);
        @(negedge clk);
        chk("done_one_cycle", done32, 0);
        rdy32 = 1'b1;
    endtask

    initial begin
        int c;
        tbl[0] = '{32'h1, 8'd3, 0, 32'h00042021, 32'h04080601, 3};
        tbl[1] = '{32'h1, 8'd3, 2, 32'h00042021, 32'h04080601, 3};
        tbl[2] = '{32'h0, 8'd0, 0, xs32(32'h2545F491), xs32(xs32(32'h2545F491)), 256};
        tbl[3] = '{32'hDEADBEEF, 8'd7, 1, xs32(32'hDEADBEEF), xs32(xs32(32'hDEADBEEF)), 7};
        tbl[4] = '{32'h80000000, 8'd1, 0, xs32(32'h80000000), 32'h0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid32", v32, 0);
        chk("rst_rand32", rn32, 0);
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_valid64", v64, 0);
        chk("rst_rand64", rn64, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) run32(tbl[i]);

        // abort in IDLE: no effect, no done pulse
        @(posedge clk); #1;
        ab32 = 1'b1;
        @(posedge clk); #1;
        ab32 = 1'b0;
        @(negedge clk);
        chk("idle_abort_done", done32, 0);
        chk("idle_abort_busy", busy32, 0);

        // Ignore in_valid while busy, then abort with a word on the bus
        begin
            logic [31:0] w;
            w = 32'h12345678;
            for (int i = 0; i < 10; i++) begin
                w = xs32(w);
                q32.push_back(w);
            end
        end
        xfer32 = 0;
        @(posedge clk); #1;
        iv32 = 1'b1; seed32 = 32'h12345678; num32 = 8'd10; rdy32 = 1'b1;
        @(posedge clk); #1;
        seed32 = 32'hFFFF0000; num32 = 8'd2;          // cycle 1: request while busy
        @(posedge clk); #1;
        iv32 = 1'b0;
        @(posedge clk); #1;
        ab32 = 1'b1;                                   // cycle 3: abort beats transfer
        @(posedge clk); #1;
        ab32 = 1'b0;
        @(negedge clk);
        chk("abort_valid", v32, 0);
        chk("abort_done", done32, 1);
        chk("abort_busy", busy32, 0);
        chk("abort_xfers", xfer32, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_more", v32, 0);
        end
        q32.delete();

        // Reset mid-run with a simultaneous request
        begin
            logic [31:0] w;
            w = 32'h5;
            for (int i = 0; i < 20; i++) begin
                w = xs32(w);
                q32.push_back(w);
            end
        end
        @(posedge clk); #1;
        iv32 = 1'b1; seed32 = 32'h5; num32 = 8'd20;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; iv32 = 1'b1; seed32 = 32'h9; num32 = 8'd4;
        @(posedge clk); #1;
        rst_n = 1'b1; iv32 = 1'b0;
        @(negedge clk);
        chk("midrst_valid", v32, 0);
        chk("midrst_rand", rn32, 0);
        chk("midrst_busy", busy32, 0);
        chk("midrst_done", done32, 0);
        @(negedge clk);
        chk("midrst_not_latched", v32, 0);
        chk("midrst_busy_after", busy32, 0);
        q32.delete();

        // 64-bit: seed 1, num 2, then back-to-back request on the done cycle
        q64.push_back(xs64(64'd1));
        q64.push_back(xs64(xs64(64'd1)));
        xfer64 = 0;
        @(posedge clk); #1;
        iv64 = 1'b1; seed64 = 64'd1; num64 = 8'd2; rdy64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0;
        @(negedge clk);
        chk("w64_load_valid", v64, 1);
        c = 0;
        while (!done64 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("w64_done", done64, 1);
        chk("w64_xfers", xfer64, 2);
        chk("w64_busy_low", busy64, 0);
        iv64 = 1'b1; seed64 = 64'd0; num64 = 8'd1;
        q64.push_back(xs64(64'h0000_0000_2545_F491));
        @(posedge clk); #1;
        iv64 = 1'b0;
        @(negedge clk);
        chk("b2b_valid", v64, 1);
        chk("b2b_busy", busy64, 1);
        chk("b2b_word", rn64, xs64(64'h0000_0000_2545_F491));
        c = 0;
        while (!done64 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("b2b_done", done64, 1);
        chk("b2b_xfers", xfer64, 3);
        chk("b2b_queue_drained", q64.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
